// File: rtl/fix_pkg.sv
// Shared FIX definitions for the transmitter and the parser side.
// Contents:
//   FIX_SOH / DELIM_DEFAULT   field delimiters (wire SOH and the loopback ';')
//   ASCII_0 / ASCII_EQ        characters used to build tags and digits
//   BEGIN_STR                 "8=FIX.4.4" without its delimiter
//   TAG_BEGIN/TAG_LEN/TAG_CKS numeric tags 8, 9 and 10
//   tx_state_t                transmitter FSM states
//   ascii_digit()             0..9 -> '0'..'9'
package fix_pkg;

    localparam logic [7:0] FIX_SOH       = 8'h01;
    localparam logic [7:0] DELIM_DEFAULT = 8'h3B;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    localparam int BEGIN_LEN = 9;
    localparam logic [7:0] BEGIN_STR [BEGIN_LEN] = '{
        8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h2E, 8'h34, 8'h2E, 8'h34
    };

    localparam int TAG_BEGIN = 8;
    localparam int TAG_LEN   = 9;
    localparam int TAG_CKS   = 10;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_HDR_BEGIN,
        TX_HDR_LEN,
        TX_BODY,
        TX_TRAILER
    } tx_state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/fix_msg_tx_if.sv
// Byte-stream handshake bundle used for both the body input and the frame
// output of fix_msg_tx.
//   valid  byte offered by the master
//   data   byte value
//   last   final byte of a body (input side) / final delimiter of a frame
//   ready  slave accepts; a byte moves when valid && ready
// Modports: master drives valid/data/last, slave drives ready.
interface fix_msg_tx_if;

    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/fix_dec3.sv
// Combinational binary -> decimal converter for values 0..999.
// Ports:
//   bin_i   in  10  value to convert
//   dig2_o  out 8   ASCII hundreds digit
//   dig1_o  out 8   ASCII tens digit
//   dig0_o  out 8   ASCII ones digit
//   ndig_o  out 2   number of significant digits (1..3, value 0 counts as 1)
module fix_dec3
    import fix_pkg::*;
(
    input  logic [9:0] bin_i,
    output logic [7:0] dig2_o,
    output logic [7:0] dig1_o,
    output logic [7:0] dig0_o,
    output logic [1:0] ndig_o
);

    logic [3:0] hund;
    logic [6:0] rem;
    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        hund   = 4'(bin_i / 10'd100);
        rem    = 7'(bin_i % 10'd100);
        tens   = 4'(rem / 7'd10);
        ones   = 4'(rem % 7'd10);
        dig2_o = ascii_digit(hund);
        dig1_o = ascii_digit(tens);
        dig0_o = ascii_digit(ones);
        if (hund != 4'd0) begin
            ndig_o = 2'd3;
        end else if (tens != 4'd0) begin
            ndig_o = 2'd2;
        end else begin
            ndig_o = 2'd1;
        end
    end

endmodule

// File: rtl/fix_msg_tx.sv
// FIX message transmitter: buffers one body, then sends
//   "8=FIX.4.4" D "9=<len>" D <body> "10=<cks>" D
// computing BodyLength and CheckSum on the fly.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   body          slave  body bytes in (valid=in_valid, data=in_data,
//                        last=in_last, ready=in_ready)
//   frame         master frame bytes out (valid=valid, data=dout,
//                        ready=out_ready, last=final D of the frame)
//   busy          out  high while a frame is being sent
//   msg_done      out  1-cycle pulse after the final D transfers
//   err_overflow  out  1-cycle pulse when an oversized body is discarded
module fix_msg_tx
    import fix_pkg::*;
#(
    parameter int         DEPTH = 256,
    parameter logic [7:0] DELIM = DELIM_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fix_msg_tx_if.slave   body,
    fix_msg_tx_if.master  frame,
    output logic          busy,
    output logic          msg_done,
    output logic          err_overflow
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] MAX_LEN = 10'(DEPTH - 1);

    tx_state_t  state_q, state_d;
    logic [9:0] len_q, len_d;       // body length, also the buffer write pointer
    logic [9:0] idx_q, idx_d;       // byte index inside the current segment
    logic [7:0] cks_q, cks_d;
    logic       ovf_q, ovf_d;
    logic       in_ready_q, in_ready_d;
    logic       msg_done_q, msg_done_d;
    logic       err_ovf_q, err_ovf_d;

    logic [7:0] mem_q [DEPTH];

    logic       accept;
    logic       xfer;
    logic       wr_en;
    logic       ovf_hit;
    logic       tx_valid;
    logic       seg_last;
    logic [7:0] tx_byte;
    logic [1:0] dpos;
    logic [1:0] dsig;

    logic [9:0] dec_in;
    logic [7:0] dig2, dig1, dig0;
    logic [1:0] ndig;

    assign accept   = body.valid && in_ready_q;
    assign tx_valid = (state_q == TX_HDR_BEGIN) || (state_q == TX_HDR_LEN) ||
                      (state_q == TX_BODY)      || (state_q == TX_TRAILER);
    assign xfer     = tx_valid && frame.ready;
    assign ovf_hit  = ovf_q || (len_q == MAX_LEN);

    // The length digits are only needed in HDR_LEN and the checksum digits
    // only in TRAILER, so one converter serves both.
    assign dec_in = (state_q == TX_TRAILER) ? {2'b00, cks_q} : len_q;

    fix_dec3 u_dec (
        .bin_i  (dec_in),
        .dig2_o (dig2),
        .dig1_o (dig1),
        .dig0_o (dig0),
        .ndig_o (ndig)
    );

    // Output byte is a pure function of registered state, so it holds
    // steady for as long as the downstream stalls.
    always_comb begin
        tx_byte  = 8'h00;
        seg_last = 1'b0;
        dpos     = idx_q[1:0] - 2'd2;
        dsig     = ndig - 2'd1 - dpos;
        case (state_q)
            TX_HDR_BEGIN: begin
                if (idx_q == 10'(BEGIN_LEN)) begin
                    tx_byte  = DELIM;
                    seg_last = 1'b1;
                end else begin
                    tx_byte = BEGIN_STR[idx_q[3:0]];
                end
            end
            TX_HDR_LEN: begin
                if (idx_q == 10'd0) begin
                    tx_byte = ascii_digit(4'(TAG_LEN));
                end else if (idx_q == 10'd1) begin
                    tx_byte = ASCII_EQ;
                end else if (idx_q == {8'd0, ndig} + 10'd2) begin
                    tx_byte  = DELIM;
                    seg_last = 1'b1;
                end else begin
                    // Most significant present digit first, no leading zeros.
                    case (dsig)
                        2'd2:    tx_byte = dig2;
                        2'd1:    tx_byte = dig1;
                        default: tx_byte = dig0;
                    endcase
                end
            end
            TX_BODY: begin
                tx_byte  = mem_q[idx_q[AW-1:0]];
                seg_last = (idx_q == len_q - 10'd1);
            end
            TX_TRAILER: begin
                case (idx_q[2:0])
                    3'd0:    tx_byte = ascii_digit(4'(TAG_CKS / 10));
                    3'd1:    tx_byte = ascii_digit(4'(TAG_CKS % 10));
                    3'd2:    tx_byte = ASCII_EQ;
                    3'd3:    tx_byte = dig2;
                    3'd4:    tx_byte = dig1;
                    3'd5:    tx_byte = dig0;
                    default: begin
                        tx_byte  = DELIM;
                        seg_last = 1'b1;
                    end
                endcase
            end
            default: begin
                tx_byte  = 8'h00;
                seg_last = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cks_d      = cks_q;
        ovf_d      = ovf_q;
        msg_done_d = 1'b0;
        err_ovf_d  = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            TX_IDLE, TX_LOAD: begin
                if (accept) begin
                    if (ovf_hit) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        len_d = len_q + 10'd1;
                    end
                    if (body.last) begin
                        idx_d = 10'd0;
                        if (ovf_hit) begin
                            // Oversized body: drop it entirely, emit nothing.
                            state_d   = TX_IDLE;
                            err_ovf_d = 1'b1;
                            len_d     = 10'd0;
                            ovf_d     = 1'b0;
                        end else begin
                            state_d = TX_HDR_BEGIN;
                        end
                    end else begin
                        state_d = TX_LOAD;
                    end
                end
            end
            TX_HDR_BEGIN, TX_HDR_LEN, TX_BODY: begin
                if (xfer) begin
                    cks_d = cks_q + tx_byte;
                    if (seg_last) begin
                        idx_d = 10'd0;
                        case (state_q)
                            TX_HDR_BEGIN: state_d = TX_HDR_LEN;
                            TX_HDR_LEN:   state_d = TX_BODY;
                            default:      state_d = TX_TRAILER;
                        endcase
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
            end
            TX_TRAILER: begin
                if (xfer) begin
                    if (seg_last) begin
                        state_d    = TX_IDLE;
                        idx_d      = 10'd0;
                        len_d      = 10'd0;
                        cks_d      = 8'h00;
                        msg_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
        // Leaving TRAILER keeps in_ready low for the msg_done cycle so a new
        // body never overlaps the tail of the previous frame.
        in_ready_d = ((state_d == TX_IDLE) || (state_d == TX_LOAD)) &&
                     (state_q != TX_TRAILER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            len_q      <= 10'd0;
            idx_q      <= 10'd0;
            cks_q      <= 8'h00;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            msg_done_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cks_q      <= cks_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            msg_done_q <= msg_done_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    // Buffer contents are not reset: clearing len makes stale bytes unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[len_q[AW-1:0]] <= body.data;
        end
    end

    assign body.ready   = in_ready_q;
    assign frame.valid  = tx_valid;
    assign frame.data   = tx_valid ? tx_byte : 8'h00;
    assign frame.last   = tx_valid && (state_q == TX_TRAILER) && seg_last;
    assign busy         = tx_valid;
    assign msg_done     = msg_done_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_fix_msg_tx.sv
module tb_fix_msg_tx;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       sel16 = 1'b0;

    always #5 clk = ~clk;

    fix_msg_tx_if b_if ();
    fix_msg_tx_if f_if ();
    fix_msg_tx_if b16_if ();
    fix_msg_tx_if f16_if ();

    logic busy, msg_done, err_ovf;
    logic busy16, msg_done16, err_ovf16;

    assign b_if.valid   = in_valid & ~sel16;
    assign b_if.data    = in_data;
    assign b_if.last    = in_last;
    assign f_if.ready   = out_ready;
    assign b16_if.valid = in_valid & sel16;
    assign b16_if.data  = in_data;
    assign b16_if.last  = in_last;
    assign f16_if.ready = out_ready;

    fix_msg_tx #(.DEPTH(256), .DELIM(8'h3B)) dut (
        .clk          (clk),
        .reset        (reset),
        .body         (b_if),
        .frame        (f_if),
        .busy         (busy),
        .msg_done     (msg_done),
        .err_overflow (err_ovf)
    );

    fix_msg_tx #(.DEPTH(16), .DELIM(8'h3B)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .body         (b16_if),
        .frame        (f16_if),
        .busy         (busy16),
        .msg_done     (msg_done16),
        .err_overflow (err_ovf16)
    );

    logic       m_ready, m_valid, m_last, m_busy, m_done, m_err;
    logic [7:0] m_dout;
    assign m_ready = sel16 ? b16_if.ready : b_if.ready;
    assign m_valid = sel16 ? f16_if.valid : f_if.valid;
    assign m_dout  = sel16 ? f16_if.data  : f_if.data;
    assign m_last  = sel16 ? f16_if.last  : f_if.last;
    assign m_busy  = sel16 ? busy16       : busy;
    assign m_done  = sel16 ? msg_done16   : msg_done;
    assign m_err   = sel16 ? err_ovf16    : err_ovf;

    int n_vec = 0;
    int n_bad = 0;

    bit       send_tmo = 1'b0;
    bit       col_tmo  = 1'b0;
    logic     post_last_valid, post_last_err;
    logic     done_now, ready_at_done, last_flag;
    int       stall_err, stall_cnt, rdy_tx_err;
    bit [7:0] bp_pat = 8'b1001_0110;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic int first_diff(input bq_t a, input bq_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    task automatic send_body(input bq_t b, input bit keep_valid);
        bit acc;
        int guard;
        for (int i = 0; i < b.size(); i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = (i == b.size() - 1);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 3000) begin
                acc = (m_ready === 1'b1);
                tick();
                guard++;
            end
            if (!acc) begin
                send_tmo = 1'b1;
                break;
            end
        end
        post_last_valid = m_valid;
        post_last_err   = m_err;
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic collect(input int n, input bit bp, output bq_t got);
        int         cyc;
        logic [7:0] prev_d;
        bit         stalled;
        bit         rdy;
        got = {};
        cyc = 0;
        prev_d = 8'h00;
        stalled = 1'b0;
        last_flag = 1'b0;
        while (got.size() < n && cyc < 5000) begin
            rdy = bp ? bp_pat[cyc % 8] : 1'b1;
            out_ready = rdy;
            if (stalled) begin
                stall_cnt++;
                if (m_valid !== 1'b1 || m_dout !== prev_d) stall_err++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) rdy_tx_err++;
            if (m_valid === 1'b1 && rdy) begin
                got.push_back(m_dout);
                if (got.size() == n) last_flag = m_last;
            end
            stalled = (m_valid === 1'b1) && !rdy;
            prev_d = m_dout;
            tick();
            cyc++;
        end
        if (got.size() < n) col_tmo = 1'b1;
        done_now      = m_done;
        ready_at_done = m_ready;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if (m_valid !== 1'b0 || m_dout !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_out: valid=%b dout=%02h, required valid=0 dout=00", m_valid, m_dout);
        end
        n_vec++;
        if (m_ready !== 1'b0 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: in_ready=%b busy=%b, required 0 0", m_ready, m_busy);
        end
        n_vec++;
        if (m_done !== 1'b0 || m_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: msg_done=%b err_overflow=%b, required 0 0", m_done, m_err);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (m_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b valid=%b, required 1 0", m_ready, m_valid);
        end
    endtask

    task automatic test_basic();
        bq_t got, exp;
        int d;
        exp = str2q("8=FIX.4.4;9=5;35=0;10=081;");
        rdy_tx_err = 0;
        fork
            send_body(str2q("35=0;"), 1'b0);
            collect(26, 1'b0, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL basic_frame: differs at byte %0d, got %0d bytes, required %0d", d, got.size(), exp.size());
        end
        n_vec++;
        if (post_last_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency: valid after in_last=%b, required 1", post_last_valid);
        end
        n_vec++;
        if (done_now !== 1'b1 || ready_at_done !== 1'b0 || last_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_done: msg_done=%b in_ready=%b last=%b, required 1 0 1", done_now, ready_at_done, last_flag);
        end
        tick();
        n_vec++;
        if (m_done !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_after: msg_done=%b in_ready=%b busy=%b, required 0 1 0", m_done, m_ready, m_busy);
        end
        n_vec++;
        if (rdy_tx_err != 0) begin
            n_bad++;
            $display("FAIL basic_ready_tx: in_ready high on %0d transmit cycles, required 0", rdy_tx_err);
        end
    endtask

    task automatic test_backpressure();
        bq_t got, exp;
        int d;
        exp = str2q("8=FIX.4.4;9=5;35=0;10=081;");
        stall_err = 0;
        stall_cnt = 0;
        fork
            send_body(str2q("35=0;"), 1'b0);
            collect(26, 1'b1, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL bp_frame: differs at byte %0d, got %0d bytes, required %0d", d, got.size(), exp.size());
        end
        n_vec++;
        if (stall_err != 0 || stall_cnt == 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d unstable of %0d stalled cycles, required 0 of >0", stall_err, stall_cnt);
        end
        n_vec++;
        if (done_now !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_done: msg_done=%b, required 1", done_now);
        end
        tick();
    endtask

    task automatic test_len3();
        bq_t body, got, exp, tmp;
        int d;
        body = {};
        for (int i = 0; i < 99; i++) body.push_back(8'h41);
        body.push_back(8'h3B);
        exp = str2q("8=FIX.4.4;9=100;");
        for (int i = 0; i < 99; i++) exp.push_back(8'h41);
        tmp = str2q(";10=251;");
        foreach (tmp[i]) exp.push_back(tmp[i]);
        fork
            send_body(body, 1'b0);
            collect(123, 1'b0, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL len3_frame: differs at byte %0d, got %0d bytes, required %0d", d, got.size(), exp.size());
        end
        n_vec++;
        if (done_now !== 1'b1) begin
            n_bad++;
            $display("FAIL len3_done: msg_done=%b, required 1", done_now);
        end
        tick();
    endtask

    task automatic test_one_byte();
        bq_t got, exp;
        int d;
        exp = str2q("8=FIX.4.4;9=1;;10=120;");
        fork
            send_body(str2q(";"), 1'b0);
            collect(22, 1'b0, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1 || post_last_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL one_byte: differs at byte %0d, got %0d bytes, first valid=%b, required 22 bytes valid=1", d, got.size(), post_last_valid);
        end
        tick();
    endtask

    task automatic test_overflow();
        bq_t body, got, exp;
        int vc, ec, d;
        sel16 = 1'b1;
        out_ready = 1'b1;
        body = {};
        for (int i = 0; i < 16; i++) body.push_back(8'h42);
        body.push_back(8'h3B);
        vc = 0;
        ec = 0;
        fork
            send_body(body, 1'b0);
            for (int c = 0; c < 30; c++) begin
                if (m_valid !== 1'b0) vc++;
                if (m_err === 1'b1) ec++;
                tick();
            end
        join
        n_vec++;
        if (post_last_err !== 1'b1 || ec != 1) begin
            n_bad++;
            $display("FAIL ovf_pulse: err after last=%b pulses=%0d, required 1 and 1", post_last_err, ec);
        end
        n_vec++;
        if (vc != 0) begin
            n_bad++;
            $display("FAIL ovf_silent: valid high %0d cycles, required 0", vc);
        end
        n_vec++;
        if (m_ready !== 1'b1 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_idle: in_ready=%b busy=%b, required 1 0", m_ready, m_busy);
        end
        exp = str2q("8=FIX.4.4;9=15;35=CCCCCCCCCCC;10=051;");
        fork
            send_body(str2q("35=CCCCCCCCCCC;"), 1'b0);
            collect(37, 1'b0, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL ovf_full_len: differs at byte %0d, got %0d bytes, required %0d", d, got.size(), exp.size());
        end
        tick();
        sel16 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bq_t got, exp;
        int d, vc, dc;
        fork
            send_body(str2q("35=0;"), 1'b0);
            collect(14, 1'b0, got);
        join
        d = first_diff(got, str2q("8=FIX.4.4;9=5;"));
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL rst_prefix: differs at byte %0d, got %0d bytes, required 14", d, got.size());
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_abort: valid=%b busy=%b in_ready=%b, required 0 0 0", m_valid, m_busy, m_ready);
        end
        vc = 0;
        dc = 0;
        for (int c = 0; c < 30; c++) begin
            if (m_valid !== 1'b0) vc++;
            if (m_done !== 1'b0) dc++;
            tick();
        end
        n_vec++;
        if (vc != 0 || dc != 0) begin
            n_bad++;
            $display("FAIL rst_no_trailer: valid cycles=%0d msg_done cycles=%0d, required 0 0", vc, dc);
        end
        exp = str2q("8=FIX.4.4;9=5;35=0;10=081;");
        fork
            send_body(str2q("35=0;"), 1'b0);
            collect(26, 1'b0, got);
        join
        d = first_diff(got, exp);
        n_vec++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL rst_recover: differs at byte %0d, got %0d bytes, required %0d", d, got.size(), exp.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bq_t g1, g2, e1, e2;
        logic done1, rdy1;
        int d1, d2;
        e1 = str2q("8=FIX.4.4;9=5;35=0;10=081;");
        e2 = str2q("8=FIX.4.4;9=10;35=A;49=X;10=203;");
        rdy_tx_err = 0;
        fork
            begin
                send_body(str2q("35=0;"), 1'b1);
                send_body(str2q("35=A;49=X;"), 1'b0);
            end
            begin
                collect(26, 1'b0, g1);
                done1 = done_now;
                rdy1  = ready_at_done;
                collect(32, 1'b0, g2);
            end
        join
        d1 = first_diff(g1, e1);
        d2 = first_diff(g2, e2);
        n_vec++;
        if (d1 != -1) begin
            n_bad++;
            $display("FAIL b2b_frame1: differs at byte %0d, got %0d bytes, required %0d", d1, g1.size(), e1.size());
        end
        n_vec++;
        if (d2 != -1) begin
            n_bad++;
            $display("FAIL b2b_frame2: differs at byte %0d, got %0d bytes, required %0d", d2, g2.size(), e2.size());
        end
        n_vec++;
        if (done1 !== 1'b1 || rdy1 !== 1'b0 || done_now !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done: done1=%b in_ready at done1=%b done2=%b, required 1 0 1", done1, rdy1, done_now);
        end
        n_vec++;
        if (rdy_tx_err != 0) begin
            n_bad++;
            $display("FAIL b2b_ready_tx: in_ready high on %0d transmit cycles, required 0", rdy_tx_err);
        end
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len3();
        test_one_byte();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (send_tmo || col_tmo) begin
            n_bad++;
            $display("FAIL timeout: send timeout=%b collect timeout=%b, required 0 0", send_tmo, col_tmo);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
